// File: rtl/store_size_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : store_size_pkg
// Brief    : Size codes and controller state encoding shared by the store
//            path and the load-size unit.
// Revision : 1.0
// ----------------------------------------------------------------------------
package store_size_pkg;

  // Size codes, common to load and store paths
  localparam logic [1:0] SZ_W   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_B   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Halfword and byte stores must preserve the untouched lanes, so they read
  // the old word first; word and reserved codes write straight through.
  function automatic logic needs_rmw(input logic [1:0] size);
    return (size == SZ_H) || (size == SZ_B);
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_size_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : store_size_ctrl_if
// Brief    : Control handshake plus data-memory port of the store controller.
//            slave = the controller, master = control unit / memory side.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface store_size_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              start;
  logic [1:0]        store_size_control;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       data_in;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  start, store_size_control, addr_in, data_in, mem_rdata,
    output busy, done, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output start, store_size_control, addr_in, data_in, mem_rdata,
    input  busy, done, mem_addr, mem_wr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/store_size_ctrl_merge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : store_merge
// Brief    : Combines new store data into the old memory word. Only the low
//            lanes are replaced, mirroring the load-size lane convention.
// Revision : 1.0
// ----------------------------------------------------------------------------
module store_merge
  import store_size_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged
);

  // Lane replacement selected by size; word/reserved pass new data through
  always_comb begin
    merged = new_data;
    case (size)
      SZ_H:    merged = {old_word[31:16], new_data[15:0]};
      SZ_B:    merged = {old_word[31:8],  new_data[7:0]};
      default: merged = new_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_size_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : store_size_ctrl
// Brief    : Multicycle store controller. Word stores write once; halfword
//            and byte stores read, wait MEM_LATENCY cycles, merge and write.
// Revision : 1.0
// ----------------------------------------------------------------------------
module store_size_ctrl
  import store_size_pkg::*;
#(
  parameter int MEM_LATENCY = 1,   // 1..7
  parameter int ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  store_size_ctrl_if.slave bus
);

  localparam int                c_cnt_w     = 3;
  localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(MEM_LATENCY - 1);

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic [1:0]          r_size;
  logic [31:0]         r_word;     // word to be written; doubles as mem_wdata
  logic                r_busy;
  logic                r_done;
  logic                r_wr;
  logic [31:0]         w_merged;

  store_merge u_merge (
    .size     (r_size),
    .old_word (bus.mem_rdata),
    .new_data (r_data),
    .merged   (w_merged)
  );

  // Controller FSM with registered outputs; latches are only loaded in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= SZ_W;
      r_word  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_wr   <= 1'b0;
          if (bus.start) begin
            r_addr <= bus.addr_in;
            r_data <= bus.data_in;
            r_size <= bus.store_size_control;
            r_busy <= 1'b1;
            if (needs_rmw(bus.store_size_control)) begin
              r_state <= ST_READ;
            end else begin
              r_word  <= bus.data_in;
              r_wr    <= 1'b1;
              r_state <= ST_WRITE;
            end
          end
        end
        ST_READ: begin
          r_cnt   <= c_wait_load;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_word  <= w_merged;
            r_wr    <= 1'b1;
            r_state <= ST_WRITE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_WRITE: begin
          r_wr    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_wr    <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mem_wr    = r_wr;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_word;

endmodule
`default_nettype wire

// File: tb/tb_store_size_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_store_size_ctrl
// Brief    : Bench for store_size_ctrl with MEM_LATENCY=1 (unit 0) and
//            MEM_LATENCY=3 (unit 1), behavioural memories and a write
//            scoreboard.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_store_size_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  store_size_ctrl_if #(.ADDR_W(32)) bus0 ();
  store_size_ctrl_if #(.ADDR_W(32)) bus1 ();

  store_size_ctrl #(.MEM_LATENCY(1), .ADDR_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  store_size_ctrl #(.MEM_LATENCY(3), .ADDR_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int checks = 0;
  int failures = 0;
  int wr_cnt[2] = '{0, 0};

  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [3];

  function automatic logic [31:0] rd0(input logic [31:0] a);
    return mem0.exists(a) ? mem0[a] : 32'h0;
  endfunction
  function automatic logic [31:0] rd1(input logic [31:0] a);
    return mem1.exists(a) ? mem1[a] : 32'h0;
  endfunction

  // Memory models: read data emerges MEM_LATENCY cycles after the address
  always @(posedge clk) begin
    pipe0 <= rd0(bus0.mem_addr);
    if (bus0.mem_wr) mem0[bus0.mem_addr] = bus0.mem_wdata;
  end
  always @(posedge clk) begin
    pipe1[0] <= rd1(bus1.mem_addr);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    if (bus1.mem_wr) mem1[bus1.mem_addr] = bus1.mem_wdata;
  end
  assign bus0.mem_rdata = pipe0;
  assign bus1.mem_rdata = pipe1[2];

  // Scoreboard monitors: every write must match the next expected entry
  always @(negedge clk) begin
    if (reset_n && bus0.mem_wr) begin
      wr_cnt[0]++;
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL u0_write: unexpected write addr=%h data=%h, want none",
                 bus0.mem_addr, bus0.mem_wdata);
      end else begin
        wr_t e;
        e = q0.pop_front();
        if (bus0.mem_addr !== e.addr || bus0.mem_wdata !== e.data) begin
          failures++;
          $display("FAIL u0_write: got addr=%h data=%h want addr=%h data=%h",
                   bus0.mem_addr, bus0.mem_wdata, e.addr, e.data);
        end
      end
    end
  end
  always @(negedge clk) begin
    if (reset_n && bus1.mem_wr) begin
      wr_cnt[1]++;
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL u1_write: unexpected write addr=%h data=%h, want none",
                 bus1.mem_addr, bus1.mem_wdata);
      end else begin
        wr_t e;
        e = q1.pop_front();
        if (bus1.mem_addr !== e.addr || bus1.mem_wdata !== e.data) begin
          failures++;
          $display("FAIL u1_write: got addr=%h data=%h want addr=%h data=%h",
                   bus1.mem_addr, bus1.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic drive(input int u, input logic s, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    if (u == 0) begin
      bus0.start = s; bus0.store_size_control = sz;
      bus0.addr_in = a; bus0.data_in = d;
    end else begin
      bus1.start = s; bus1.store_size_control = sz;
      bus1.addr_in = a; bus1.data_in = d;
    end
  endtask

  function automatic logic done_of(input int u);
    return (u == 0) ? bus0.done : bus1.done;
  endfunction
  function automatic logic busy_of(input int u);
    return (u == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic [31:0] addr_of(input int u);
    return (u == 0) ? bus0.mem_addr : bus1.mem_addr;
  endfunction

  function automatic void push_exp(input int u, input logic [31:0] a,
                                   input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  // Wait for done (bounded); returns cycles since the start cycle
  task automatic wait_done(input int u, output int c);
    c = 1;
    while (!done_of(u) && c < 30) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  // One request; inputs are scrambled right after the start cycle
  task automatic run_op(input int u, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_w,
                        input int exp_lat, input string name);
    int w0;
    int c;
    w0 = wr_cnt[u];
    @(negedge clk);
    drive(u, 1'b1, sz, a, d);
    push_exp(u, a, exp_w);
    @(posedge clk); #1;
    drive(u, 1'b0, ~sz, ~a, 32'h0);
    checks++;
    if (busy_of(u) !== 1'b1 || addr_of(u) !== a) begin
      failures++;
      $display("FAIL %s_first_cycle: got busy=%b addr=%h want busy=1 addr=%h",
               name, busy_of(u), addr_of(u), a);
    end
    wait_done(u, c);
    checks++;
    if (c != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, c, exp_lat);
    end
    @(posedge clk); #1;
    checks++;
    if (done_of(u) !== 1'b0 || busy_of(u) !== 1'b0) begin
      failures++;
      $display("FAIL %s_after_done: got done=%b busy=%b want 0 0",
               name, done_of(u), busy_of(u));
    end
    checks++;
    if (wr_cnt[u] - w0 != 1) begin
      failures++;
      $display("FAIL %s_write_count: got %0d want 1", name, wr_cnt[u] - w0);
    end
  endtask

  task automatic test_reset;
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus0.busy, bus0.done, bus0.mem_wr, bus0.mem_addr, bus0.mem_wdata} !== 67'h0 ||
        {bus1.busy, bus1.done, bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata} !== 67'h0) begin
      failures++;
      $display("FAIL reset_outputs: got u0 b=%b d=%b w=%b a=%h wd=%h want all 0",
               bus0.busy, bus0.done, bus0.mem_wr, bus0.mem_addr, bus0.mem_wdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // abort an sh in WAIT: no write may follow
    begin
      int w0;
      w0 = wr_cnt[0];
      @(negedge clk);
      drive(0, 1'b1, 2'b01, 32'h44, 32'h55556666);
      @(posedge clk); #1;
      drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
      @(posedge clk); #1;
      checks++;
      if (bus0.busy !== 1'b1) begin
        failures++;
        $display("FAIL reset_pre_busy: got %b want 1", bus0.busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus0.mem_wr !== 1'b0 || bus0.busy !== 1'b0 || bus0.mem_addr !== 32'h0) begin
        failures++;
        $display("FAIL reset_mid_op: got wr=%b busy=%b addr=%h want 0 0 0",
                 bus0.mem_wr, bus0.busy, bus0.mem_addr);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wr_cnt[0] != w0 || rd0(32'h44) !== 32'h11223344 || bus0.busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_abandon: got writes=%0d mem=%h busy=%b want 0 11223344 0",
                 wr_cnt[0] - w0, rd0(32'h44), bus0.busy);
      end
    end
  endtask

  task automatic test_sw;
    run_op(0, 2'b00, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 2, "sw");
    checks++;
    if (rd0(32'h40) !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_mem: got %h want deadbeef", rd0(32'h40));
    end
  endtask

  task automatic test_sh_merge;
    run_op(0, 2'b01, 32'h44, 32'hAAAABBBB, 32'h1122BBBB, 4, "sh");
    checks++;
    if (rd0(32'h44) !== 32'h1122BBBB) begin
      failures++;
      $display("FAIL sh_mem: got %h want 1122bbbb", rd0(32'h44));
    end
  endtask

  task automatic test_sb_lat3;
    run_op(1, 2'b10, 32'h48, 32'hFFFFFFCC, 32'h112233CC, 6, "sb_l3");
    run_op(1, 2'b01, 32'h60, 32'h00001234, 32'hDEAD1234, 6, "sh_l3");
  endtask

  task automatic test_reserved;
    run_op(0, 2'b11, 32'h4C, 32'hCAFEF00D, 32'hCAFEF00D, 2, "rsv");
    checks++;
    if (rd0(32'h4C) !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL rsv_mem: got %h want cafef00d", rd0(32'h4C));
    end
  endtask

  task automatic test_start_busy;
    int w0;
    int c;
    w0 = wr_cnt[0];
    @(negedge clk);
    drive(0, 1'b1, 2'b10, 32'h50, 32'h000000EE);
    push_exp(0, 32'h50, 32'hA1B2C3EE);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b10, 32'h0, 32'h0);          // READ
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b00, 32'h50, 32'h12345678);  // WAIT: must be ignored
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
    wait_done(0, c);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_cnt[0] - w0 != 1 || rd0(32'h50) !== 32'hA1B2C3EE) begin
      failures++;
      $display("FAIL busy_ignore: got writes=%0d mem=%h want 1 a1b2c3ee",
               wr_cnt[0] - w0, rd0(32'h50));
    end
    run_op(0, 2'b00, 32'h50, 32'h12345678, 32'h12345678, 2, "reissue");
    checks++;
    if (rd0(32'h50) !== 32'h12345678) begin
      failures++;
      $display("FAIL reissue_mem: got %h want 12345678", rd0(32'h50));
    end
  endtask

  // Back-to-back random requests on the slow unit against a lane model
  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      logic [1:0]  sz;
      logic [31:0] a, d, old, e;
      int lat;
      sz  = 2'($urandom_range(0, 3));
      a   = 32'h70 + 32'($urandom_range(0, 3));
      d   = $urandom;
      old = rd1(a);
      case (sz)
        2'b01:   e = {old[31:16], d[15:0]};
        2'b10:   e = {old[31:8], d[7:0]};
        default: e = d;
      endcase
      lat = (sz == 2'b01 || sz == 2'b10) ? 6 : 2;
      run_op(1, sz, a, d, e, lat, "b2b");
      checks++;
      if (rd1(a) !== e) begin
        failures++;
        $display("FAIL b2b_mem: got %h want %h", rd1(a), e);
      end
    end
  endtask

  initial begin
    mem0[32'h44] = 32'h11223344;
    mem0[32'h50] = 32'hA1B2C3D4;
    mem1[32'h48] = 32'h11223344;
    mem1[32'h60] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) mem1[32'h70 + 32'(i)] = 32'h0F1E2D3C ^ 32'(i);
    test_reset();
    test_sw();
    test_sh_merge();
    test_sb_lat3();
    test_reserved();
    test_start_busy();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL pending_writes: got %0d/%0d want 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_size_ctrl.md
Name: store_size_ctrl

Overview:
- Multicycle store-path controller: the write-direction counterpart of the load-size unit.
- Takes a register value plus a size code (sw/sh/sb) and commits it to data memory.
- sw: single write. sh/sb: read-modify-write, replacing only the low halfword or byte of the addressed word and preserving the rest.
- Sits between the control unit (start/done handshake) and the data memory port (address, write enable, data in/out).

Parameters:
- MEM_LATENCY, 1: cycles from read address presented to mem_rdata valid; legal range 1..7.
- ADDR_W, 32: memory address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- store_size_control  input  2  00=sw, 01=sh, 10=sb, 11=reserved (handled as sw).
- addr_in  input  ADDR_W  word address of the store.
- data_in  input  32  register value (B register).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle completion pulse.
- mem_addr  output  ADDR_W  memory address.
- mem_wr  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, wait counter=0. All latches cleared: addr, data, size, merged word. busy=0, done=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: mem_wr drops immediately and the operation is abandoned. No partial write is retried.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: busy=0, mem_wr=0.
  - On start=1: latch addr_in, data_in, store_size_control.
  - Next state: WRITE for sw/11, READ for sh/sb.
  - start=0: stay in IDLE.
- READ: one cycle. mem_addr=latched addr, mem_wr=0, counter loaded with MEM_LATENCY-1. Next state: WAIT.
- WAIT: holds mem_addr, mem_wr=0.
  - Counter decrements each cycle.
  - In the cycle where counter==0, capture mem_rdata and build the merged word. Next state: WRITE.
  - Total WAIT length is exactly MEM_LATENCY cycles.
- Merge rules (low lanes only, matching the load-size lane convention):
  - sh: {rdata[31:16], data[15:0]}.
  - sb: {rdata[31:8], data[7:0]}.
- WRITE: one cycle. mem_wr=1, mem_addr=latched addr.
  - mem_wdata = latched data for sw/11, merged word for sh/sb.
  - Next state: DONE.
- DONE: one cycle. done=1, mem_wr=0. Next state: IDLE.
- busy=1 in READ, WAIT, WRITE and DONE.
- start while busy=1 is ignored, with no queueing. start is a don't-care in DONE; a new request is accepted only in IDLE, the cycle after done.
- Inputs addr_in/data_in/store_size_control may change freely after the start cycle; only the latched copies are used.
- mem_wdata holds its last value outside WRITE; consumers must qualify it with mem_wr.
- Latency from the start edge to the done cycle:
  - sw: 2 cycles.
  - sh/sb: 3+MEM_LATENCY cycles (4 at default).
- Exactly one mem_wr cycle per accepted request.

Decomposition:
- Shared package (store_size_pkg) holds:
  - size codes SZ_W=2'b00, SZ_H=2'b01, SZ_B=2'b10, SZ_RSV=2'b11;
  - state enum ST_IDLE, ST_READ, ST_WAIT, ST_WRITE, ST_DONE.
- The load-size unit should import the same size codes.
- One natural combinational sub-module, store_merge (size, old word, new data -> merged word). It is instantiated once; the FSM, counter and latches stay in the top module.

Test Plan:
- Reset, sw write, sh merge, and start-while-busy below assume MEM_LATENCY=1.
- Reset: reset_n=0 mid-WAIT of an sh -> mem_wr=0, busy=0 same cycle. After release, IDLE; next start accepted normally.
- sw write: start, size=00, addr=0x40, data=0xDEADBEEF -> WRITE one cycle later with mem_wr=1, mem_wdata=0xDEADBEEF; done one cycle after that; exactly one mem_wr pulse.
- sh merge: mem[0x44]=0x11223344, data=0xAAAABBBB -> READ at 0x44, WAIT, then write 0x1122BBBB. done 4 cycles after the start edge.
- sb merge with MEM_LATENCY=3: mem[0x48]=0x11223344, data=0xFFFFFFCC -> WAIT lasts 3 cycles, write 0x112233CC, done 6 cycles after start.
- Start while busy: second start with size=00, data=0x12345678 issued during WAIT of an sb -> ignored; only one mem_wr. Memory ends with the sb result. Re-issue after done succeeds.
- Reserved size and input hold: size=11, data=0xCAFEF00D, with data_in changed to 0 the cycle after start -> behaves as sw, writes 0xCAFEF00D.
